// File: rtl/victim_cache_control_if.sv
// ---------------------------------------------------------------------------
// victim_cache_control_if
//
// Bundles the handshakes between the victim-cache controller, the L1, the
// victim-cache datapath and physical memory.
//
//   L1 side      : l1_req, l1_dirty_in (to ctrl); l1_resp (from ctrl)
//   Datapath side: tag_match, valid, valid_reg_out, dirty_reg_out (to ctrl);
//                  ld_cache, l1_dirty, miss_get (from ctrl)
//   Pmem side    : pmem_resp (to ctrl); pmem_read, pmem_write (from ctrl)
//
// Modports:
//   master - the controller (drives strobes and requests)
//   slave  - the environment (L1, datapath, pmem)
// ---------------------------------------------------------------------------
interface victim_cache_control_if;
  logic l1_req;
  logic l1_dirty_in;
  logic l1_resp;
  logic tag_match;
  logic valid;
  logic valid_reg_out;
  logic dirty_reg_out;
  logic ld_cache;
  logic l1_dirty;
  logic miss_get;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport master (
    input  l1_req, l1_dirty_in, tag_match, valid, valid_reg_out,
           dirty_reg_out, pmem_resp,
    output l1_resp, ld_cache, l1_dirty, miss_get, pmem_read, pmem_write
  );

  modport slave (
    output l1_req, l1_dirty_in, tag_match, valid, valid_reg_out,
           dirty_reg_out, pmem_resp,
    input  l1_resp, ld_cache, l1_dirty, miss_get, pmem_read, pmem_write
  );
endinterface

// File: rtl/victim_cache_control.sv
// ---------------------------------------------------------------------------
// victim_cache_control
//
// Sequencing FSM for a 4-entry fully-associative victim cache sitting between
// the L1 and physical memory. On an L1 miss request it looks up the victim
// cache; a hit swaps the entry with the L1 eviction, a miss installs the
// eviction over the LRU entry, writes back the displaced victim if it was
// valid and dirty, then fetches the requested line from pmem.
//
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   io        - victim_cache_control_if.master (L1 / datapath / pmem)
//   pmem_err  - sticky pmem timeout flag, cleared only by reset
//
// Parameters:
//   FETCH_TIMEOUT - cycles to wait for pmem_resp in WRITEBACK or FETCH
//                   before giving up; 0 disables the timeout.
//
// Optional build macro VC_PERF_COUNTERS_EN adds saturating 16-bit outputs
// hit_count, miss_count and wb_count.
// ---------------------------------------------------------------------------
module victim_cache_control #(
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  victim_cache_control_if.master io,
  output logic                   pmem_err
`ifdef VC_PERF_COUNTERS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count,
  output logic [15:0]            wb_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, SWAP, WRITEBACK, FETCH, RESPOND
  } state_t;

  localparam int unsigned TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (FETCH_TIMEOUT != 0);
  localparam logic [TW-1:0] T_FULL = TW'(FETCH_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

  state_t        state, cur, next;
  logic          hit_q;          // tag_match captured during LOOKUP
  logic          victim_pending; // first cycle after a miss SWAP
  logic          from_pmem;      // RESPOND data came through FETCH
  logic [TW-1:0] timer;
  logic          err_q;
  logic          wait_st, timed_out, expire;

  assign pmem_err = err_q;

  // The datapath registers the displaced entry's valid/dirty on the ld_cache
  // edge, so the writeback decision can only be made in the cycle after SWAP.
  // The FSM parks in FETCH and is redirected to WRITEBACK for that one cycle
  // when the victim needs writing back, so no pmem cycle is lost.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    cur = state;
    if (victim_pending && io.valid_reg_out && io.dirty_reg_out) cur = WRITEBACK;

    wait_st   = (cur == WRITEBACK) || (cur == FETCH);
    timed_out = TIMEOUT_EN && wait_st && (timer == T_FULL);
    expire    = TIMEOUT_EN && wait_st && !timed_out && !io.pmem_resp &&
                (timer == T_LAST);

    next          = cur;
    io.l1_resp    = 1'b0;
    io.ld_cache   = 1'b0;
    io.l1_dirty   = 1'b0;
    io.miss_get   = 1'b0;
    io.pmem_read  = 1'b0;
    io.pmem_write = 1'b0;

    case (cur)
      IDLE:   if (io.l1_req) next = LOOKUP;
      LOOKUP: next = SWAP;
      SWAP: begin
        io.ld_cache = 1'b1;
        io.l1_dirty = io.l1_dirty_in;
        next        = hit_q ? RESPOND : FETCH;
      end
      WRITEBACK: begin
        // On expiry the request is dropped and the L1 is answered anyway.
        if (timed_out) next = RESPOND;
        else begin
          io.pmem_write = 1'b1;
          if (io.pmem_resp) next = FETCH;
        end
      end
      FETCH: begin
        io.miss_get = 1'b1;
        if (timed_out) next = RESPOND;
        else begin
          io.pmem_read = 1'b1;
          if (io.pmem_resp) next = RESPOND;
        end
      end
      RESPOND: begin
        io.l1_resp  = 1'b1;
        io.miss_get = from_pmem;
        next        = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hit_q          <= 1'b0;
      victim_pending <= 1'b0;
      from_pmem      <= 1'b0;
      timer          <= '0;
      err_q          <= 1'b0;
    end else begin
      state          <= next;
      victim_pending <= (cur == SWAP) && !hit_q;
      if (cur == LOOKUP) hit_q <= io.tag_match;
      if (next == RESPOND && cur != RESPOND) from_pmem <= (cur == FETCH);
      // Counter restarts whenever a wait state is entered or left.
      if (TIMEOUT_EN && wait_st && next == cur) timer <= timer + TW'(1);
      else                                      timer <= '0;
      if (expire) err_q <= 1'b1;
    end
  end

`ifdef VC_PERF_COUNTERS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (cur == SWAP) begin
        if (hit_q) hit_count  <= sat_inc(hit_count);
        else       miss_count <= sat_inc(miss_count);
      end
      if (cur == WRITEBACK && next != WRITEBACK) wb_count <= sat_inc(wb_count);
    end
  end
`endif

endmodule

// File: doc/victim_cache_control.md
Name: victim_cache_control

Overview:
- FSM that sequences the 4-entry fully-associative victim cache datapath between the L1 and physical memory.
- On an L1 miss it performs the lookup and swap on a hit. On a miss it installs the L1 eviction, writes back a dirty displaced victim, then fetches the requested line from pmem.
- Drives the datapath strobes (ld_cache, miss_get, pmem_write select) and the L1/pmem handshakes.

Parameters:
- FETCH_TIMEOUT, 0, cycles to wait for pmem_resp before flagging pmem_err; 0 = never time out.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- l1_req  in  1  L1 miss request; held until l1_resp. Eviction line and address are valid while high.
- l1_dirty_in  in  1  dirty bit of the L1 eviction line; forwarded to the datapath.
- l1_resp  out  1  one-cycle pulse: mem_rdata is valid for the L1.
- tag_match  in  1  datapath combinational hit on the lookup tag.
- valid  in  1  valid bit of the currently indexed entry.
- valid_reg_out  in  1  registered valid of the displaced entry.
- dirty_reg_out  in  1  registered dirty of the displaced entry.
- ld_cache  out  1  one-cycle install/swap strobe to the arrays, regs and LRU.
- l1_dirty  out  1  dirty value written with the install (equals l1_dirty_in while in SWAP).
- miss_get  out  1  selects pmem_rdata onto mem_rdata.
- pmem_read  out  1  pmem read request; held until pmem_resp.
- pmem_write  out  1  pmem write request (also the datapath address select); held until pmem_resp.
- pmem_resp  in  1  pmem completion, one cycle.
- pmem_err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ld_cache, l1_resp, miss_get, pmem_read, pmem_write, l1_dirty, pmem_err all 0. Outstanding pmem requests are dropped immediately. Release is synchronous to the next clk edge.
- States: IDLE, LOOKUP, SWAP, WRITEBACK, FETCH, RESPOND.
- IDLE: l1_req=1 -> LOOKUP.
- LOOKUP: one cycle for datapath tag compare. Capture hit=tag_match into an internal flag. Always -> SWAP.
- SWAP: ld_cache=1 for exactly one cycle. l1_dirty=l1_dirty_in.
  - Hit: the indexed entry swaps with the L1 eviction. -> RESPOND, miss_get=0.
  - Miss: the LRU entry is overwritten and its valid/dirty/data are captured in the datapath regs.
  - Miss, next cycle: valid_reg_out & dirty_reg_out -> WRITEBACK; else -> FETCH.
- WRITEBACK: pmem_write=1 until pmem_resp; then -> FETCH. pmem_read=0 throughout.
- FETCH: pmem_read=1, miss_get=1 until pmem_resp. On pmem_resp -> RESPOND, holding miss_get=1.
- RESPOND: l1_resp=1 for one cycle. miss_get holds its FETCH value (1 if the line came from pmem, 0 on hit). -> IDLE.
- Latency:
  - Hit: l1_resp 3 cycles after l1_req is sampled (LOOKUP, SWAP, RESPOND).
  - Clean miss: 3 + pmem latency.
  - Dirty miss: 3 + two pmem latencies.
- pmem_read and pmem_write are never asserted together. ld_cache is never asserted outside SWAP.
- Exactly one ld_cache pulse per l1_req, so the LRU updates once per request.
- l1_req dropped before l1_resp: protocol violation. The FSM completes the current sequence and the RESPOND pulse is still issued.
- l1_req still high in the cycle after RESPOND: treated as a new request (IDLE -> LOOKUP).
- Timeout (FETCH_TIMEOUT>0): a counter clears on entry to WRITEBACK or FETCH. If it reaches FETCH_TIMEOUT without pmem_resp:
  - pmem_err=1, the request drops;
  - -> RESPOND (l1_resp issued with stale data).
- pmem_resp arriving in any state other than WRITEBACK/FETCH is ignored.

Optional Feature:
- VC_PERF_COUNTERS_EN: adds outputs hit_count, miss_count, wb_count (16 bits each, saturating at 16'hFFFF, reset to 0).
  - hit_count or miss_count increments on the SWAP cycle, according to the hit flag.
  - wb_count increments on WRITEBACK exit.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset held, then released with l1_req=0 -> all outputs 0, state IDLE for 10 cycles.
- Hit (tag_match=1 in LOOKUP) -> ld_cache pulses exactly at cycle 2. l1_resp=1 at cycle 3 with miss_get=0; no pmem activity.
- Clean miss (tag_match=0, valid_reg_out=1, dirty_reg_out=0), pmem_resp after 5 cycles -> ld_cache once. pmem_read high 5 cycles, pmem_write never high. l1_resp with miss_get=1.
- Dirty miss (valid_reg_out=1, dirty_reg_out=1), pmem latency 4 -> pmem_write high 4 cycles, then pmem_read high 4 cycles, never overlapping. l1_resp at cycle 3+4+4.
- reset_n asserted mid-FETCH -> pmem_read and miss_get drop asynchronously. No l1_resp; the next request behaves as a fresh hit.
- FETCH_TIMEOUT=8, pmem_resp never arrives -> pmem_err=1 after 8 cycles, l1_resp one cycle later, pmem_err stays 1 until reset. With VC_PERF_COUNTERS_EN, 3 hits + 2 misses give hit_count=3, miss_count=2.
